// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU has fixed priority,
// the DMA gets a starvation guard and a bounded locked burst.
module dmem_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_wen,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_wen,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
  localparam int unsigned BCW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_t;

  arb_state_t     r_state;
  arb_state_t     w_state_nx;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_nx;
  logic [BCW-1:0] r_beat_cnt;
  logic [BCW-1:0] w_beat_nx;
  logic           w_cpu_gnt;
  logic           w_dma_gnt;
  logic           w_wait_full;
  logic           w_beat_full;
  logic           r_cpu_rvalid;
  logic           r_dma_rvalid;
  logic [DW-1:0]  r_cpu_rdata;
  logic [DW-1:0]  r_dma_rdata;

  assign w_wait_full = (r_wait_cnt == WCW'(MAX_WAIT));
  assign w_beat_full = (r_beat_cnt == BCW'(BURST_MAX));

  // State, starvation counter and burst beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_CPU;
      r_wait_cnt <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_wait_cnt <= w_wait_nx;
      r_beat_cnt <= w_beat_nx;
    end
  end

  // Winner selection and next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat_cnt;
    w_wait_nx  = r_wait_cnt;
    w_cpu_gnt  = 1'b0;
    w_dma_gnt  = 1'b0;

    if (r_state == ARB_DMA && dma_req && dma_lock) begin
      if (w_beat_full && cpu_req) begin
        w_cpu_gnt  = 1'b1;
        w_state_nx = ARB_CPU;
        w_beat_nx  = '0;
      end else begin
        w_dma_gnt = 1'b1;
        if (!w_beat_full) w_beat_nx = r_beat_cnt + BCW'(1);
      end
    end else begin
      // Burst ended (or never started): this cycle is arbitrated normally
      w_state_nx = ARB_CPU;
      w_beat_nx  = '0;
      if (cpu_req && dma_req) begin
        if (w_wait_full) w_dma_gnt = 1'b1;
        else             w_cpu_gnt = 1'b1;
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (dma_req) begin
        w_dma_gnt = 1'b1;
      end
      if (w_dma_gnt && dma_lock) begin
        w_state_nx = ARB_DMA;
        w_beat_nx  = BCW'(1);
      end
    end

    if (!rst_n) begin
      w_cpu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
    end

    if (w_dma_gnt)                   w_wait_nx = '0;
    else if (dma_req && !w_wait_full) w_wait_nx = r_wait_cnt + WCW'(1);
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign dma_gnt   = w_dma_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;

  assign mem_cs    = w_cpu_gnt | w_dma_gnt;
  assign mem_addr  = w_dma_gnt ? dma_addr  : (w_cpu_gnt ? cpu_addr  : '0);
  assign mem_wdata = w_dma_gnt ? dma_wdata : (w_cpu_gnt ? cpu_wdata : '0);
  assign mem_wen   = w_dma_gnt ? dma_wen   : (w_cpu_gnt ? cpu_wen   : 1'b1);

  // Read return tracking; rdata passes mem_rdata through on the valid cycle and holds after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt & cpu_wen;
      r_dma_rvalid <= w_dma_gnt & dma_wen;
      if (r_cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (r_dma_rvalid) r_dma_rdata <= mem_rdata;
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign dma_rdata  = r_dma_rvalid ? mem_rdata : r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level arbitration model predicts
// each cycle's winner and read data; a negedge monitor compares against the DUT.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int unsigned AW = 16, DW = 16, MAX_WAIT = 4, BURST_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req = 1'b0, cpu_wen = 1'b1, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, cpu_rdata;
  logic dma_req = 1'b0, dma_lock = 1'b0, dma_wen = 1'b1, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0, dma_rdata;
  logic mem_cs, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_wen(dma_wen), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 16) ? 16'hBEEF : 16'((i * 257) ^ 23130);
  endfunction

  // Synchronous single-port memory, 256 words decoded from addr[7:0]
  logic [DW-1:0] tb_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_cs) begin
        if (!mem_wen) tb_mem[mem_addr[7:0]] <= mem_wdata;
        else          mem_rdata <= tb_mem[mem_addr[7:0]];
      end
    end
  end

  typedef struct {int cyc; int who; logic [AW-1:0] addr; logic wen; logic [DW-1:0] wdata;} xfer_t;
  typedef struct {int cyc; logic [DW-1:0] data;} rd_t;
  xfer_t xq[$];
  rd_t   crq[$];
  rd_t   drq[$];

  int tests = 0, failed = 0, cyc = 0;
  int mon_cpu_n = 0, mon_dma_n = 0;
  logic [DW-1:0] ref_mem [256];
  bit m_burst;
  int m_beats, m_denied, last_who;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arbitration: who (0 none, 1 CPU, 2 DMA) wins with the current requests
  task automatic model_eval();
    int who;
    xfer_t e;
    rd_t r;
    who = 0;
    if (m_burst && dma_req && dma_lock) begin
      if (m_beats == BURST_MAX && cpu_req) begin
        who = 1; m_burst = 0; m_beats = 0;
      end else begin
        who = 2;
        if (m_beats < BURST_MAX) m_beats++;
      end
    end else begin
      m_burst = 0; m_beats = 0;
      if (cpu_req && dma_req) who = (m_denied == MAX_WAIT) ? 2 : 1;
      else if (cpu_req)       who = 1;
      else if (dma_req)       who = 2;
      if (who == 2 && dma_lock) begin m_burst = 1; m_beats = 1; end
    end
    if (who == 2)                            m_denied = 0;
    else if (dma_req && m_denied < MAX_WAIT) m_denied++;
    last_who = who;
    if (who != 0) begin
      e.cyc = cyc; e.who = who;
      e.addr  = (who == 1) ? cpu_addr  : dma_addr;
      e.wen   = (who == 1) ? cpu_wen   : dma_wen;
      e.wdata = (who == 1) ? cpu_wdata : dma_wdata;
      xq.push_back(e);
      if (e.wen) begin
        r.cyc = cyc + 1; r.data = ref_mem[e.addr[7:0]];
        if (who == 1) crq.push_back(r); else drq.push_back(r);
      end else begin
        ref_mem[e.addr[7:0]] = e.wdata;
      end
    end
  endtask

  task automatic do_cycle();
    cyc++;
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    xq.delete(); crq.delete(); drq.delete();
    m_burst = 0; m_beats = 0; m_denied = 0; last_who = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // New request only once the previous one was accepted (inputs stay stable while stalled)
  task automatic gen_cpu(input int rate);
    if (!cpu_req || last_who == 1) begin
      cpu_req   = ($urandom_range(0, 99) < rate);
      cpu_addr  = AW'($urandom_range(0, 255));
      cpu_wen   = 1'($urandom_range(0, 1));
      cpu_wdata = DW'($urandom);
    end
  endtask

  task automatic gen_dma(input int rate, input int lock_pct);
    if (!dma_req || last_who == 2) begin
      dma_req   = ($urandom_range(0, 99) < rate);
      dma_lock  = ($urandom_range(0, 99) < lock_pct);
      dma_addr  = AW'($urandom_range(0, 255));
      dma_wen   = 1'($urandom_range(0, 1));
      dma_wdata = DW'($urandom);
    end
  endtask

  // Monitor: compares every cycle's grant, memory port and read returns
  always @(negedge clk) begin : monitor
    xfer_t e;
    bit has;
    rd_t r;
    if (rst_n) begin
      has = (xq.size() > 0) && (xq[0].cyc == cyc);
      if (has) e = xq.pop_front();
      else begin e.cyc = cyc; e.who = 0; e.addr = '0; e.wen = 1'b1; e.wdata = '0; end
      check("winner", {30'd0, dma_gnt, cpu_gnt}, 32'(e.who));
      check("mem_cs", 32'(mem_cs), 32'(has));
      check("mem_wen", 32'(mem_wen), 32'(e.wen));
      if (has) begin
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (!e.wen) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
      check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && e.who != 1));
      has = (crq.size() > 0) && (crq[0].cyc == cyc);
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(has));
      if (has) begin r = crq.pop_front(); check("cpu_rdata", 32'(cpu_rdata), 32'(r.data)); end
      has = (drq.size() > 0) && (drq[0].cyc == cyc);
      check("dma_rvalid", 32'(dma_rvalid), 32'(has));
      if (has) begin r = drq.pop_front(); check("dma_rdata", 32'(dma_rdata), 32'(r.data)); end
      if (cpu_gnt) mon_cpu_n++;
      if (dma_gnt) mon_dma_n++;
    end
  end

  initial begin
    int bc, bd, dleft;
    int rates [4][3] = '{'{60, 50, 40}, '{90, 95, 90}, '{30, 80, 70}, '{100, 100, 0}};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    flush_model();
    apply_reset();
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_mem_wen", 32'(mem_wen), 1);

    // CPU-only read of 0x0010
    cpu_req = 1; cpu_addr = 16'h0010; cpu_wen = 1; dma_req = 0;
    #1 check("t1_cpu_gnt", 32'(cpu_gnt), 1);
    do_cycle();
    cpu_req = 0;
    #1 check("t1_rvalid", 32'(cpu_rvalid), 1);
    check("t1_rdata", 32'(cpu_rdata), 32'h0000BEEF);
    check("t1_dma_rvalid", 32'(dma_rvalid), 0);
    repeat (2) do_cycle();

    // Continuous contention without lock: DMA wins every fifth cycle
    apply_reset();
    bc = mon_cpu_n; bd = mon_dma_n;
    repeat (20) begin gen_cpu(100); gen_dma(100, 0); do_cycle(); end
    check("t2_cpu_grants", 32'(mon_cpu_n - bc), 16);
    check("t2_dma_grants", 32'(mon_dma_n - bd), 4);

    // Locked burst of writes against a busy CPU
    apply_reset();
    bc = mon_cpu_n; bd = mon_dma_n; dleft = 12;
    repeat (17) begin
      gen_cpu(100);
      if (!dma_req || last_who == 2) begin
        dma_req = (dleft > 0); dleft--;
        dma_lock = 1; dma_wen = 0;
        dma_addr = AW'($urandom_range(0, 255)); dma_wdata = DW'($urandom);
      end
      do_cycle();
    end
    check("t3_cpu_grants", 32'(mon_cpu_n - bc), 8);
    check("t3_dma_grants", 32'(mon_dma_n - bd), 9);

    // Lock dropped after three beats while the CPU requests
    apply_reset();
    repeat (3) begin
      if (!dma_req || last_who == 2) begin
        dma_req = 1; dma_lock = 1; dma_wen = 0;
        dma_addr = AW'($urandom_range(0, 255)); dma_wdata = DW'($urandom);
      end
      do_cycle();
    end
    cpu_req = 1; cpu_wen = 1; cpu_addr = 16'h0042;
    dma_lock = 0; dma_addr = 16'h0043; dma_wdata = 16'h5555;
    #1 check("t4_cpu_gnt", 32'(cpu_gnt), 1);
    check("t4_dma_gnt", 32'(dma_gnt), 0);
    do_cycle();
    repeat (8) begin gen_cpu(70); gen_dma(70, 50); do_cycle(); end

    // DMA write then CPU read-back
    apply_reset();
    dma_req = 1; dma_lock = 0; dma_wen = 0; dma_addr = 16'h0020; dma_wdata = 16'h1234;
    #1 check("t5_write_wen", 32'(mem_wen), 0);
    do_cycle();
    dma_req = 0; cpu_req = 1; cpu_wen = 1; cpu_addr = 16'h0020;
    #1 check("t5_read_wen", 32'(mem_wen), 1);
    do_cycle();
    cpu_req = 0;
    #1 check("t5_rdata", 32'(cpu_rdata), 32'h00001234);
    do_cycle();

    // Reset asserted while a read return is in flight
    apply_reset();
    cpu_req = 1; cpu_wen = 1; cpu_addr = 16'h0030;
    do_cycle();
    rst_n = 0;
    flush_model();
    #1 check("t6_rvalid", 32'(cpu_rvalid), 0);
    check("t6_mem_cs", 32'(mem_cs), 0);
    check("t6_mem_wen", 32'(mem_wen), 1);
    check("t6_cpu_gnt", 32'(cpu_gnt), 0);
    @(posedge clk);
    #1 rst_n = 1;
    dma_req = 1; dma_lock = 0; dma_wen = 1; dma_addr = 16'h0031;
    #1 check("t6_fresh_cpu_gnt", 32'(cpu_gnt), 1);
    do_cycle();
    repeat (10) begin gen_cpu(100); gen_dma(100, 0); do_cycle(); end

    // Randomised traffic in phases of differing load and lock probability
    for (int ph = 0; ph < 4; ph++) begin
      repeat (1500) begin gen_cpu(rates[ph][0]); gen_dma(rates[ph][1], rates[ph][2]); do_cycle(); end
    end
    cpu_req = 0; dma_req = 0;
    repeat (3) do_cycle();
    check("xq_drained", 32'(xq.size()), 0);
    check("crq_drained", 32'(crq.size()), 0);
    check("drq_drained", 32'(drq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
